// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: FSM state encoding, port indices and
// the winner-selection function. The optional fairness feature is controlled
// by the MEM_ARBITER_STREAK_EN macro in mem_arbiter.sv.
package mem_arbiter_pkg;

  // Symbolic view of the arbiter FSM, matching the localparam encodings below.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  // Port indices: video scan-out fetcher and CPU bus.
  localparam logic PORT_VID = 1'b0;
  localparam logic PORT_CPU = 1'b1;

  // Width of the grant-streak counter; holds MAX_STREAK up to 15.
  localparam int STREAK_W = 4;

  // Video wins by default; the CPU wins when it is the only requester or when
  // the video port has used up its streak allowance while the CPU waited.
  function automatic logic pick_winner(input logic p0v, input logic p1v,
                                       input logic streak_hit);
    return (p1v && (!p0v || streak_hit)) ? PORT_CPU : PORT_VID;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared SDRAM controller port. Port 0 (video) has
// fixed priority; port 1 (CPU) is protected from starvation by a grant-streak
// limit when MEM_ARBITER_STREAK_EN is defined. Without the macro the arbiter
// is strict port-0 priority and MAX_STREAK has no effect.
//
// Handshake semantics: a requester raises pN_valid_i and holds its fields
// stable until it sees the one-cycle pN_ready_o pulse; the request is then
// latched and the requester may present its next request, which waits until
// the arbiter is back in IDLE. On the memory side mem_valid_o and the latched
// fields stay stable until a cycle with mem_ready_i=1 completes the transfer.
// Completion is reported with a one-cycle pN_rsp_o pulse (rdata_o valid for
// reads). Every output is driven straight from a flop.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                p0_valid_i,
  input  logic                p0_we_i,
  input  logic [ADDR_W-1:0]   p0_addr_i,
  input  logic [DATA_W-1:0]   p0_wdata_i,
  input  logic [DATA_W/8-1:0] p0_wmask_i,
  output logic                p0_ready_o,
  output logic                p0_rsp_o,
  input  logic                p1_valid_i,
  input  logic                p1_we_i,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic [DATA_W-1:0]   p1_wdata_i,
  input  logic [DATA_W/8-1:0] p1_wmask_i,
  output logic                p1_ready_o,
  output logic                p1_rsp_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [1:0]          dbg_state_o
);

  logic [1:0]          state_q, state_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic                mem_valid_q, mem_valid_d;
  logic                p0_ready_q, p0_ready_d;
  logic                p1_ready_q, p1_ready_d;
  logic                p0_rsp_q, p0_rsp_d;
  logic                p1_rsp_q, p1_rsp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                streak_hit;
  logic                win;

  assign win = pick_winner(p0_valid_i, p1_valid_i, streak_hit);

`ifdef MEM_ARBITER_STREAK_EN
  logic [STREAK_W-1:0] streak_q, streak_d;

  assign streak_hit = (streak_q == STREAK_W'(MAX_STREAK));

  // Count consecutive video grants taken while the CPU was waiting.
  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE && (p0_valid_i || p1_valid_i)) begin
      if (win == PORT_VID && p1_valid_i) begin
        streak_d = streak_hit ? streak_q : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) streak_q <= '0;
    else         streak_q <= streak_d;
  end
`else
  // Strict video priority. MAX_STREAK is only legal in 1..15, so this is
  // always false; it keeps the parameter referenced in this build.
  assign streak_hit = (MAX_STREAK < 0);
`endif

  // Arbiter FSM: grant in IDLE, present to memory in ISSUE, then wait for
  // read data (WAIT) or acknowledge a write (ACK).
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    mem_valid_d = mem_valid_q;
    p0_ready_d  = 1'b0;
    p1_ready_d  = 1'b0;
    p0_rsp_d    = 1'b0;
    p1_rsp_d    = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (p0_valid_i || p1_valid_i) begin
          port_d      = win;
          mem_valid_d = 1'b1;
          state_d     = ST_ISSUE;
          if (win == PORT_CPU) begin
            we_d       = p1_we_i;
            addr_d     = p1_addr_i;
            wdata_d    = p1_wdata_i;
            wmask_d    = p1_wmask_i;
            p1_ready_d = 1'b1;
          end else begin
            we_d       = p0_we_i;
            addr_d     = p0_addr_i;
            wdata_d    = p0_wdata_i;
            wmask_d    = p0_wmask_i;
            p0_ready_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ready_i) begin
          mem_valid_d = 1'b0;
          if (we_q) begin
            // The write completes here; ACK is the cycle the pulse is seen.
            state_d  = ST_ACK;
            p0_rsp_d = (port_q == PORT_VID);
            p1_rsp_d = (port_q == PORT_CPU);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d  = mem_rdata_i;
          p0_rsp_d = (port_q == PORT_VID);
          p1_rsp_d = (port_q == PORT_CPU);
          state_d  = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_VID;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      mem_valid_q <= 1'b0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      p0_rsp_q    <= 1'b0;
      p1_rsp_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      mem_valid_q <= mem_valid_d;
      p0_ready_q  <= p0_ready_d;
      p1_ready_q  <= p1_ready_d;
      p0_rsp_q    <= p0_rsp_d;
      p1_rsp_q    <= p1_rsp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign p0_ready_o  = p0_ready_q;
  assign p1_ready_o  = p1_ready_q;
  assign p0_rsp_o    = p0_rsp_q;
  assign p1_rsp_o    = p1_rsp_q;
  assign rdata_o     = rdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled on
// the falling clock edge. The contention step follows MEM_ARBITER_STREAK_EN.
module tb_mem_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int MW     = DATA_W / 8;

  logic              clk;
  logic              reset_i;
  logic              p0_valid_i, p0_we_i, p0_ready_o, p0_rsp_o;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_wdata_i;
  logic [MW-1:0]     p0_wmask_i;
  logic              p1_valid_i, p1_we_i, p1_ready_o, p1_rsp_o;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_wdata_i;
  logic [MW-1:0]     p1_wmask_i;
  logic [DATA_W-1:0] rdata_o;
  logic              mem_valid_o, mem_ready_i, mem_we_o, mem_rvalid_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
  logic [MW-1:0]     mem_wmask_o;
  logic [1:0]        dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(4)) dut (
    .clk(clk), .reset_i(reset_i),
    .p0_valid_i(p0_valid_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
    .p0_wdata_i(p0_wdata_i), .p0_wmask_i(p0_wmask_i),
    .p0_ready_o(p0_ready_o), .p0_rsp_o(p0_rsp_o),
    .p1_valid_i(p1_valid_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
    .p1_wdata_i(p1_wdata_i), .p1_wmask_i(p1_wmask_i),
    .p1_ready_o(p1_ready_o), .p1_rsp_o(p1_rsp_o),
    .rdata_o(rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p0_ready"}, p0_ready_o, 0);
    check({tag, "_p1_ready"}, p1_ready_o, 0);
    check({tag, "_p0_rsp"}, p0_rsp_o, 0);
    check({tag, "_p1_rsp"}, p1_rsp_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_mem_valid"}, mem_valid_o, 0);
    check({tag, "_mem_we"}, mem_we_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_mem_wmask"}, mem_wmask_o, 0);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  logic [9:0] exp_grants;
  int         n_grants;

  initial begin
    reset_i = 1'b1;
    p0_valid_i = 0; p0_we_i = 0; p0_addr_i = '0; p0_wdata_i = '0; p0_wmask_i = '0;
    p1_valid_i = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0; p1_wmask_i = '0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_i = 1'b0;
    tick();

    // Lone CPU read of 0x000100
    p1_valid_i = 1; p1_we_i = 0; p1_addr_i = 24'h000100;
    tick();
    check("rd_p1_ready", p1_ready_o, 1);
    check("rd_p0_ready", p0_ready_o, 0);
    check("rd_mem_valid", mem_valid_o, 1);
    check("rd_mem_we", mem_we_o, 0);
    check("rd_mem_addr", mem_addr_o, 24'h000100);
    p1_valid_i = 0;
    mem_ready_i = 1;
    tick();
    check("rd_state_wait", dbg_state_o, 2);
    check("rd_mem_valid_drop", mem_valid_o, 0);
    check("rd_ready_single", p1_ready_o, 0);
    mem_ready_i = 0;
    tick();
    check("rd_no_early_rsp_a", p1_rsp_o, 0);
    tick();
    check("rd_no_early_rsp_b", p1_rsp_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    check("rd_p1_rsp", p1_rsp_o, 1);
    check("rd_p0_rsp", p0_rsp_o, 0);
    check("rd_rdata", rdata_o, 32'hDEADBEEF);
    check("rd_state_idle", dbg_state_o, 0);
    mem_rvalid_i = 0; mem_rdata_i = 32'h11111111;
    tick();
    check("rd_rsp_one_cycle", p1_rsp_o, 0);
    check("rd_rdata_hold", rdata_o, 32'hDEADBEEF);

    // Video write with memory always ready
    p0_valid_i = 1; p0_we_i = 1; p0_addr_i = 24'h000010;
    p0_wdata_i = 32'h12345678; p0_wmask_i = 4'hF;
    mem_ready_i = 1;
    tick();
    check("wr_p0_ready", p0_ready_o, 1);
    check("wr_p1_ready", p1_ready_o, 0);
    check("wr_mem_valid", mem_valid_o, 1);
    check("wr_mem_we", mem_we_o, 1);
    check("wr_mem_addr", mem_addr_o, 24'h000010);
    check("wr_mem_wdata", mem_wdata_o, 32'h12345678);
    check("wr_mem_wmask", mem_wmask_o, 4'hF);
    p0_valid_i = 0;
    tick();
    check("wr_p0_rsp", p0_rsp_o, 1);
    check("wr_state_ack", dbg_state_o, 3);
    check("wr_mem_valid_drop", mem_valid_o, 0);
    tick();
    check("wr_rsp_one_cycle", p0_rsp_o, 0);
    check("wr_state_idle", dbg_state_o, 0);
    mem_ready_i = 0;

    // Backpressure: CPU write held off for 5 cycles while video queues a request
    p1_valid_i = 1; p1_we_i = 1; p1_addr_i = 24'h000055;
    p1_wdata_i = 32'hA5A5A5A5; p1_wmask_i = 4'h3;
    tick();
    check("bp_p1_ready", p1_ready_o, 1);
    p1_valid_i = 0;
    p0_valid_i = 1; p0_we_i = 1; p0_addr_i = 24'h000077;
    p0_wdata_i = 32'h0BADF00D; p0_wmask_i = 4'hC;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_mem_valid_%0d", i), mem_valid_o, 1);
      check($sformatf("bp_mem_addr_%0d", i), mem_addr_o, 24'h000055);
      check($sformatf("bp_mem_wdata_%0d", i), mem_wdata_o, 32'hA5A5A5A5);
      check($sformatf("bp_mem_wmask_%0d", i), mem_wmask_o, 4'h3);
      check($sformatf("bp_mem_we_%0d", i), mem_we_o, 1);
      check($sformatf("bp_p0_ready_%0d", i), p0_ready_o, 0);
      check($sformatf("bp_p1_ready_%0d", i), p1_ready_o, 0);
    end
    mem_ready_i = 1;
    tick();
    check("bp_p1_rsp", p1_rsp_o, 1);
    check("bp_p0_ready_in_ack", p0_ready_o, 0);
    mem_ready_i = 0;
    tick();
    check("bp_back_idle", dbg_state_o, 0);
    check("bp_p0_ready_in_idle", p0_ready_o, 0);
    tick();
    check("bp_p0_granted", p0_ready_o, 1);
    check("bp_p0_addr", mem_addr_o, 24'h000077);
    check("bp_p0_wmask", mem_wmask_o, 4'hC);
    p0_valid_i = 0;
    mem_ready_i = 1;
    tick();
    check("bp_p0_rsp", p0_rsp_o, 1);
    tick();
    mem_ready_i = 0;

    // Contention: both ports request writes continuously
`ifdef MEM_ARBITER_STREAK_EN
    exp_grants = 10'b10000_10000;
`else
    exp_grants = 10'b00000_00000;
`endif
    p0_valid_i = 1; p0_we_i = 1; p0_addr_i = 24'h000020; p0_wdata_i = 32'h00000020; p0_wmask_i = 4'hF;
    p1_valid_i = 1; p1_we_i = 1; p1_addr_i = 24'h000030; p1_wdata_i = 32'h00000030; p1_wmask_i = 4'hF;
    mem_ready_i = 1;
    n_grants = 0;
    for (int cyc = 0; cyc < 100 && n_grants < 10; cyc++) begin
      tick();
      if (p0_ready_o || p1_ready_o) begin
        check($sformatf("ct_grant_%0d_port", n_grants), p1_ready_o, exp_grants[n_grants]);
        check($sformatf("ct_grant_%0d_onehot", n_grants), p0_ready_o ^ p1_ready_o, 1);
        check($sformatf("ct_grant_%0d_addr", n_grants), mem_addr_o,
              exp_grants[n_grants] ? 24'h000030 : 24'h000020);
        n_grants++;
      end
    end
    check("ct_grant_count", n_grants, 10);
    p0_valid_i = 0; p1_valid_i = 0;
    tick();
    tick();
    check("ct_drain_idle", dbg_state_o, 0);
    tick();
    check("ct_no_extra_p0", p0_ready_o, 0);
    check("ct_no_extra_p1", p1_ready_o, 0);
    mem_ready_i = 0;

    // Reset in the middle of a read
    p0_valid_i = 1; p0_we_i = 0; p0_addr_i = 24'h000040;
    tick();
    check("rst_p0_ready", p0_ready_o, 1);
    p0_valid_i = 0;
    mem_ready_i = 1;
    tick();
    check("rst_state_wait", dbg_state_o, 2);
    mem_ready_i = 0;
    reset_i = 1;
    #1;
    check("rst_async_mem_valid", mem_valid_o, 0);
    check("rst_async_state", dbg_state_o, 0);
    @(negedge clk);
    check_all_zero("rst_mid");
    reset_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    check("rst_late_p0_rsp", p0_rsp_o, 0);
    check("rst_late_p1_rsp", p1_rsp_o, 0);
    check("rst_late_rdata", rdata_o, 0);
    check("rst_late_state", dbg_state_o, 0);
    mem_rvalid_i = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
